// File: rtl/sfsram_ccc_cfg_pkg.sv
// Shared definitions for the FCCC dynamic-configuration APB initiator.
//   cmd_e     : fabric command encodings on REQ_CMD
//   state_e   : control FSM states
//   CCC_ADDR_W / CCC_DATA_W : CCC configuration bus widths
//   max_int() : elaboration helper used to size the shared counter
package sfsram_ccc_cfg_pkg;

    localparam int CCC_ADDR_W = 6;
    localparam int CCC_DATA_W = 8;

    typedef enum logic [1:0] {
        CMD_READ    = 2'b00,
        CMD_WRITE   = 2'b01,
        CMD_COMMIT  = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_RESP      = 3'd3,
        ST_ARST      = 3'd4,
        ST_WAIT_LOCK = 3'd5
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sfsram_sync2.sv
// Two-flop synchroniser for a single-bit asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, both stages clear to 0
//   d   : asynchronous input
//   q   : synchronised output (two destination-clock cycles of latency)
module sfsram_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sfsram_ccc_apb_cfg_master.sv
// APB initiator driving the FCCC dynamic-configuration port.
// Fabric commands (read / write / commit) are accepted one at a time while
// REQ_READY is high. Reads and writes run one two-phase APB transfer (the CCC
// has no PREADY/PSLVERR). A commit pulses PLL_ARST_N low, then waits for the
// synchronised LOCK, ignoring it for a short blanking window, and reports a
// timeout error if it never arrives.
// Ports:
//   PCLK, RESET                 : clock, asynchronous active-high reset
//   REQ_VALID/READY/CMD/ADDR/WDATA : command channel (READY high only in IDLE)
//   RSP_VALID/RDATA/ERR         : one-cycle completion, read data held
//   LOCK, LOCK_STATUS, LOCK_LOST : async PLL lock, its synchronised copy, sticky loss flag
//   PRESET_N PSEL PENABLE PWRITE PADDR PWDATA PRDATA : APB to the CCC
//   PLL_ARST_N                  : CCC PLL reset, active-low
// All outputs come straight from flops.
module sfsram_ccc_apb_cfg_master
    import sfsram_ccc_cfg_pkg::*;
#(
    parameter int ARST_CYCLES  = 16,
    parameter int LOCK_BLANK   = 4,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                  PCLK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [1:0]            REQ_CMD,
    input  logic [CCC_ADDR_W-1:0] REQ_ADDR,
    input  logic [CCC_DATA_W-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [CCC_DATA_W-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    input  logic                  LOCK,
    output logic                  LOCK_STATUS,
    output logic                  LOCK_LOST,
    output logic                  PRESET_N,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [CCC_ADDR_W-1:0] PADDR,
    output logic [CCC_DATA_W-1:0] PWDATA,
    input  logic [CCC_DATA_W-1:0] PRDATA,
    output logic                  PLL_ARST_N
);

    localparam int CNT_W = $clog2(max_int(ARST_CYCLES, LOCK_TIMEOUT)) + 1;

    localparam logic [CNT_W-1:0] ARST_LAST    = CNT_W'(ARST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END    = CNT_W'(LOCK_BLANK);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};

    state_e                  state_q,      state_d;
    logic [CNT_W-1:0]        cnt_q,        cnt_d;
    logic                    req_ready_q,  req_ready_d;
    logic                    rsp_valid_q,  rsp_valid_d;
    logic                    rsp_err_q,    rsp_err_d;
    logic [CCC_DATA_W-1:0]   rsp_rdata_q,  rsp_rdata_d;
    logic                    lock_lost_q,  lock_lost_d;
    logic                    lock_prev_q,  lock_prev_d;
    logic                    preset_n_q,   preset_n_d;
    logic                    psel_q,       psel_d;
    logic                    penable_q,    penable_d;
    logic                    pwrite_q,     pwrite_d;
    logic [CCC_ADDR_W-1:0]   paddr_q,      paddr_d;
    logic [CCC_DATA_W-1:0]   pwdata_q,     pwdata_d;
    logic                    pll_arst_n_q, pll_arst_n_d;

    logic lock_sync;
    logic lock_fall;
    logic in_commit;
    cmd_e req_cmd;

    sfsram_sync2 u_lock_sync (
        .clk (PCLK),
        .rst (RESET),
        .d   (LOCK),
        .q   (lock_sync)
    );

    assign req_cmd   = cmd_e'(REQ_CMD);
    assign lock_fall = lock_prev_q & ~lock_sync;
    assign in_commit = (state_q == ST_ARST) || (state_q == ST_WAIT_LOCK);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        lock_lost_d  = lock_lost_q;
        lock_prev_d  = lock_sync;
        preset_n_d   = 1'b1;
        psel_d       = 1'b0;
        penable_d    = 1'b0;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pll_arst_n_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                // req_ready_q is still low on the first edge after reset, so
                // a command present then is not taken.
                if (REQ_VALID && req_ready_q) begin
                    unique case (req_cmd)
                        CMD_READ, CMD_WRITE: begin
                            state_d  = ST_SETUP;
                            psel_d   = 1'b1;
                            paddr_d  = REQ_ADDR;
                            pwrite_d = (req_cmd == CMD_WRITE);
                            pwdata_d = (req_cmd == CMD_WRITE) ? REQ_WDATA : '0;
                        end
                        CMD_COMMIT: begin
                            state_d      = ST_ARST;
                            pll_arst_n_d = 1'b0;
                            cnt_d        = '0;
                            lock_lost_d  = 1'b0;
                        end
                        default: begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
                // The CCC has no PREADY: every access completes in one cycle.
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                if (!pwrite_q) begin
                    rsp_rdata_d = PRDATA;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            ST_ARST: begin
                if (cnt_q == ARST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    pll_arst_n_d = 1'b0;
                    cnt_d        = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (lock_sync && (cnt_q >= BLANK_END)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Placed after the case so a loss seen in IDLE overrides the clear
        // done by a commit accepted on the same edge.
        if (lock_fall && !in_commit) begin
            lock_lost_d = 1'b1;
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            lock_lost_q  <= 1'b0;
            lock_prev_q  <= 1'b0;
            preset_n_q   <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pll_arst_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            lock_lost_q  <= lock_lost_d;
            lock_prev_q  <= lock_prev_d;
            preset_n_q   <= preset_n_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pll_arst_n_q <= pll_arst_n_d;
        end
    end

    assign REQ_READY   = req_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign LOCK_STATUS = lock_sync;
    assign LOCK_LOST   = lock_lost_q;
    assign PRESET_N    = preset_n_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PLL_ARST_N  = pll_arst_n_q;

endmodule
